// File: rtl/uart_mon_pkg.sv
// Shared types and divider helpers for the UART TX line monitor.
package uart_mon_pkg;

  // Receiver frame states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_mon_state_e;

  // Smallest divider that still leaves a usable mid-bit sampling window.
  localparam int MIN_DIV = 8;

  // Clock cycles per bit.
  function automatic int uart_div(input int clk, input int baud);
    return clk / baud;
  endfunction

  // True when the clock divides evenly into bit periods of at least MIN_DIV cycles.
  function automatic bit uart_div_ok(input int clk, input int baud);
    return (baud > 0) && ((clk % baud) == 0) && ((clk / baud) >= MIN_DIV);
  endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word fall-through byte FIFO with sticky overflow flag.
module uart_mon_fifo
  import uart_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic [AW:0] level,
  output logic        overflow
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_mon_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  assign valid = !empty;
  assign level = wr_ptr - rd_ptr;
  // Head is forced to zero while empty so the output is defined out of reset.
  assign data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // Pointer and overflow control.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  // Byte storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_monitor.sv
// 8N1 receiver for the PULPino console line, feeding a valid/ready byte stream.
module uart_tx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 781250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        frame_err_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int DIV  = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  if (!uart_div_ok(CLK_FREQ, BAUD_RATE)) begin : g_bad_div
    $error("uart_tx_monitor: CLK_FREQ/BAUD_RATE must be an integer >= 8");
  end

  logic            rx_p0;
  logic            rx_s;
  logic            rx_prev;
  uart_mon_state_e state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            frame_err;
  logic            push;

  // Two-stage synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx_i;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM: half-bit start qualification, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit so a following start edge is never missed.
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LSB-first shift register loaded at each mid-bit data sample.
  always_ff @(posedge clk) begin
    if ((state == DATA) && (cnt == DIV_M1)) shreg <= {rx_s, shreg[7:1]};
  end

  // Push in the stop-sample cycle itself so the byte is visible on the next cycle.
  assign push        = (state == STOP) && (cnt == DIV_M1) && rx_s;
  assign frame_err_o = frame_err;

  uart_mon_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(shreg),
    .ready    (ready_i),
    .data     (data_o),
    .valid    (valid_o),
    .level    (level_o),
    .overflow (overflow_o)
  );

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Scoreboard bench for uart_tx_monitor at 25 MHz / 781250 baud (32 cycles per bit).
module tb_uart_tx_monitor;

  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic [4:0] level_o;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int         valid_cnt = 0;
  int         fe_cnt = 0;
  logic       fe_prev = 1'b0;

  always #20 clk = ~clk;

  uart_tx_monitor #(
    .CLK_FREQ  (25_000_000),
    .BAUD_RATE (781250),
    .FIFO_DEPTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one 8N1 frame. stop_low stretches a low stop bit
  // over that many bit times. rdy_pulse raises ready_i for exactly the cycle whose
  // closing edge is the stop-bit sample (cycle 307 after the start-bit drive).
  task automatic send(input logic [7:0] b, input int stop_low, input bit rdy_pulse);
    rx_i = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      idle(BIT);
    end
    if (stop_low > 0) begin
      rx_i = 1'b0;
      idle(stop_low * BIT);
    end
    rx_i = 1'b1;
    if (rdy_pulse) begin
      idle(18);
      ready_i = 1'b1;
      idle(1);
      ready_i = 1'b0;
      idle(BIT - 19);
    end else begin
      idle(BIT);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // Monitor: consumes the stream and compares against the expected-byte queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (valid_o) valid_cnt++;
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_extra: got byte 0x%02h, required none", data_o);
          end else begin
            exp_b = exp_q.pop_front();
            check("stream_data", data_o, exp_b);
          end
        end
        if (frame_err_o) begin
          fe_cnt++;
          check("frame_err_width", fe_prev, 0);
        end
        fe_prev = frame_err_o;
      end else begin
        fe_prev = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    @(negedge clk);
    idle(3);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_level", level_o, 0);
    rst = 1'b0;
    idle(5);

    // Single byte, consumer always ready.
    ready_i = 1'b1;
    valid_cnt = 0;
    exp_q.push_back(8'h65);
    send(8'h65, 0, 0);
    idle(10);
    check("single_valid_cycles", valid_cnt, 1);
    check("single_frame_err", fe_cnt, 0);
    check("single_overflow", overflow_o, 0);
    check("single_drained", exp_q.size(), 0);

    // Glitch rejection followed by a good frame.
    valid_cnt = 0;
    rx_i = 1'b0;
    idle(10);
    rx_i = 1'b1;
    idle(60);
    check("glitch_no_push", valid_cnt, 0);
    check("glitch_level", level_o, 0);
    exp_q.push_back(8'hA5);
    send(8'hA5, 0, 0);
    idle(10);
    check("glitch_next_drained", exp_q.size(), 0);

    // Framing error: stop bit low for two bit times.
    fe_cnt = 0;
    send(8'h3C, 2, 0);
    idle(5);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_level", level_o, 0);
    exp_q.push_back(8'h0F);
    send(8'h0F, 0, 0);
    idle(10);
    check("ferr_next_drained", exp_q.size(), 0);
    check("ferr_no_more_pulses", fe_cnt, 1);

    // Overflow: 17 frames into a 16-deep FIFO with no consumer.
    ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send(8'(i), 0, 0);
    end
    idle(4);
    check("ovf_level", level_o, 16);
    check("ovf_flag", overflow_o, 1);
    check("ovf_head", data_o, 8'h00);
    ready_i = 1'b1;
    idle(30);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_level_empty", level_o, 0);
    check("ovf_sticky", overflow_o, 1);
    ready_i = 1'b0;
    do_reset(2);
    check("ovf_cleared_by_rst", overflow_o, 0);
    idle(3);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send(8'(8'h20 + i), 0, 0);
    end
    idle(2);
    check("pp_level_full", level_o, 16);
    exp_q.push_back(8'h55);
    send(8'h55, 0, 1);
    idle(4);
    check("pp_level_kept", level_o, 16);
    check("pp_no_overflow", overflow_o, 0);
    check("pp_head", data_o, 8'h21);
    ready_i = 1'b1;
    idle(30);
    check("pp_drained", exp_q.size(), 0);
    check("pp_level_empty", level_o, 0);

    // Reset in the middle of data bit 4 of 0xFF, with a stale byte buffered.
    ready_i = 1'b0;
    send(8'h77, 0, 0);
    idle(2);
    check("mid_pre_level", level_o, 1);
    rx_i = 1'b0;
    idle(BIT);
    rx_i = 1'b1;
    idle(4 * BIT + 16);
    do_reset(1);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_level", level_o, 0);
    check("mid_rst_frame_err", frame_err_o, 0);
    check("mid_rst_overflow", overflow_o, 0);
    idle(9 * BIT - 4 * BIT - 16 - 1);
    idle(4);
    check("mid_no_push", level_o, 0);
    ready_i = 1'b1;
    exp_q.push_back(8'h12);
    send(8'h12, 0, 0);
    idle(10);
    check("mid_next_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
